// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_pkg
// Description : Shared opcode map and sequencer state encoding for the 16-bit
//               accumulator CPU. Holds the opcode constants, the state
//               encoding and a helper that classifies ALU opcodes.
// Contents    : c_op_* opcode constants (8-bit opcode field)
//               c_st_* sequencer state codes (c_state_w bits)
//               is_alu_op()  opcode -> 1 when it is an accumulator ALU op
// Revision    : 1.0  initial release
// ============================================================================
package instr_sequencer_pkg;

    // Opcode map (instruction word bits [15:8])
    localparam logic [7:0] c_op_nop = 8'h00;
    localparam logic [7:0] c_op_not = 8'h01;
    localparam logic [7:0] c_op_xor = 8'h02;
    localparam logic [7:0] c_op_or  = 8'h03;
    localparam logic [7:0] c_op_and = 8'h04;
    localparam logic [7:0] c_op_sub = 8'h05;
    localparam logic [7:0] c_op_add = 8'h06;
    localparam logic [7:0] c_op_rr  = 8'h07;
    localparam logic [7:0] c_op_rl  = 8'h08;
    localparam logic [7:0] c_op_dec = 8'h09;
    localparam logic [7:0] c_op_inc = 8'h0A;
    localparam logic [7:0] c_op_ldi = 8'h0B;
    localparam logic [7:0] c_op_ld  = 8'h0C;
    localparam logic [7:0] c_op_st  = 8'h0D;
    localparam logic [7:0] c_op_jmp = 8'h0E;
    localparam logic [7:0] c_op_jma = 8'h0F;
    localparam logic [7:0] c_op_cll = 8'h10;
    localparam logic [7:0] c_op_ret = 8'h11;
    localparam logic [7:0] c_op_rst = 8'h12;

    // Sequencer state encoding
    localparam int unsigned          c_state_w   = 3;
    localparam logic [c_state_w-1:0] c_st_fetch  = 3'd0;
    localparam logic [c_state_w-1:0] c_st_decode = 3'd1;
    localparam logic [c_state_w-1:0] c_st_exec   = 3'd2;
    localparam logic [c_state_w-1:0] c_st_mem    = 3'd3;
    localparam logic [c_state_w-1:0] c_st_halt   = 3'd4;

    // Opcodes that take one EXEC cycle and write the accumulator
    function automatic logic is_alu_op(input logic [7:0] op);
        logic r;
        case (op)
            c_op_not, c_op_xor, c_op_or,  c_op_and,
            c_op_sub, c_op_add, c_op_rr,  c_op_rl,
            c_op_dec, c_op_inc, c_op_ldi: r = 1'b1;
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack
// Description : Hardware return-address LIFO for CLL/RET. DEPTH entries of
//               DATA_W bits. Pushes while full and pops while empty are
//               dropped; the caller is expected to check full/empty first.
// Ports       : clk, rst (async, active-high)
//               push, push_data  store push_data on top
//               pop              discard the top entry
//               clear            empty the stack (wins over push/pop)
//               top_data         current top entry (valid when !empty)
//               full, empty      occupancy flags
// Revision    : 1.0  initial release
// ============================================================================
module ret_stack
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              clear,
    output logic [DATA_W-1:0] top_data,
    output logic              full,
    output logic              empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] w_wr_ptr;
    logic [c_ptr_w-1:0] w_top_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    // The occupancy count doubles as the write pointer; top is one below it.
    assign w_wr_ptr  = r_count[c_ptr_w-1:0];
    assign w_top_ptr = w_wr_ptr - c_ptr_one;
    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign top_data  = r_mem[w_top_ptr];
    assign w_do_push = push && !full && !clear;
    assign w_do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + c_cnt_one;
        end else if (w_do_pop) begin
            r_count <= r_count - c_cnt_one;
        end
    end

    // Entry storage needs no reset: an entry is only read after being pushed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Fetch/decode/execute control unit of the 16-bit accumulator
//               CPU. Fetches instruction words, decodes the opcode, sequences
//               data-memory accesses, drives the ALU controls and the
//               accumulator strobes, and keeps the PC plus a return stack.
// Ports       : clk, rst                     clock, async active-high reset
//               instr_req/addr/ack/data      program-memory read handshake
//               mem_req/we/addr/ack          data-memory handshake
//               acc_value                    accumulator (JMA target source)
//               alu_op, alu_funct            ALU controls
//               imm, in1_sel_imm             immediate operand path (LDI)
//               acc_we, acc_clr              accumulator strobes (pulses)
//               fault                        sticky stack over/underflow
//               illegal                      pulse on undefined opcode
// Revision    : 1.0  initial release
// ============================================================================
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              instr_req,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ack,
    input  logic [WIDTH-1:0]  instr_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WIDTH-1:0]  acc_value,
    output logic [7:0]        alu_op,
    output logic              alu_funct,
    output logic [WIDTH-1:0]  imm,
    output logic              in1_sel_imm,
    output logic              acc_we,
    output logic              acc_clr,
    output logic              fault,
    output logic              illegal
);

    localparam logic [ADDR_W-1:0] c_pc_one = ADDR_W'(1);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_nxt;
    logic [WIDTH-1:0]     r_ir;
    logic [WIDTH-1:0]     w_ir_nxt;
    logic                 r_fault;
    logic                 w_fault_set;
    // Low in reset and set on the first clock after release, so instr_req
    // drops the instant rst rises and only reappears one clock after release.
    logic                 r_started;

    logic [7:0]           w_opcode;
    logic [ADDR_W-1:0]    w_operand;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_sclr;
    logic [ADDR_W-1:0]    w_stk_top;
    logic                 w_stk_full;
    logic                 w_stk_empty;

    logic                 w_unused_acc;

    assign w_opcode     = r_ir[WIDTH-1 -: 8];
    assign w_operand    = r_ir[ADDR_W-1:0];
    assign instr_addr   = r_pc;
    assign imm          = WIDTH'(w_operand);
    assign alu_funct    = 1'b0;
    assign fault        = r_fault;
    assign w_unused_acc = ^acc_value[WIDTH-1:ADDR_W];

    ret_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (ADDR_W)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (r_pc),
        .pop       (w_pop),
        .clear     (w_sclr),
        .top_data  (w_stk_top),
        .full      (w_stk_full),
        .empty     (w_stk_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_fetch;
            r_pc      <= '0;
            r_ir      <= '0;
            r_fault   <= 1'b0;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_ir      <= w_ir_nxt;
            r_started <= 1'b1;
            if (w_fault_set) begin
                r_fault <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_fault_set = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_sclr      = 1'b0;
        instr_req   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        alu_op      = c_op_nop;
        in1_sel_imm = 1'b0;
        acc_we      = 1'b0;
        acc_clr     = 1'b0;
        illegal     = 1'b0;

        case (r_state)
            c_st_fetch: begin
                instr_req = r_started;
                if (r_started && instr_ack) begin
                    w_ir_nxt    = instr_data;
                    w_pc_nxt    = r_pc + c_pc_one;
                    w_state_nxt = c_st_decode;
                end
            end

            c_st_decode: begin
                alu_op      = w_opcode;
                w_state_nxt = c_st_fetch;
                case (w_opcode)
                    c_op_ld, c_op_st: w_state_nxt = c_st_mem;
                    c_op_jmp:         w_pc_nxt    = w_operand;
                    c_op_jma:         w_pc_nxt    = acc_value[ADDR_W-1:0];
                    c_op_cll: begin
                        if (w_stk_full) begin
                            w_fault_set = 1'b1;
                            w_state_nxt = c_st_halt;
                        end else begin
                            // r_pc already points past the CLL: that is the return address
                            w_push   = 1'b1;
                            w_pc_nxt = w_operand;
                        end
                    end
                    c_op_ret: begin
                        if (w_stk_empty) begin
                            w_fault_set = 1'b1;
                            w_state_nxt = c_st_halt;
                        end else begin
                            w_pop    = 1'b1;
                            w_pc_nxt = w_stk_top;
                        end
                    end
                    c_op_nop: begin
                    end
                    c_op_rst: begin
                        w_pc_nxt = '0;
                        w_sclr   = 1'b1;
                        acc_clr  = 1'b1;
                    end
                    default: begin
                        if (is_alu_op(w_opcode)) begin
                            w_state_nxt = c_st_exec;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                endcase
            end

            c_st_exec: begin
                alu_op      = w_opcode;
                acc_we      = 1'b1;
                in1_sel_imm = (w_opcode == c_op_ldi);
                w_state_nxt = c_st_fetch;
            end

            c_st_mem: begin
                alu_op   = w_opcode;
                mem_req  = 1'b1;
                mem_addr = w_operand;
                mem_we   = (w_opcode == c_op_st);
                if (mem_ack) begin
                    // LD: the ALU passes the read data, captured on the ack cycle
                    acc_we      = (w_opcode != c_op_st);
                    w_state_nxt = c_st_fetch;
                end
            end

            c_st_halt: begin
            end

            default: w_state_nxt = c_st_fetch;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Randomized self-checking bench for instr_sequencer. Random
//               programs run against an instruction-level model of the CPU
//               control flow (PC, call stack, fault) with randomly delayed
//               and spurious memory acknowledges.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              instr_req;
    logic [ADDR_W-1:0] instr_addr;
    logic              instr_ack = 1'b0;
    logic [WIDTH-1:0]  instr_data = '0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [WIDTH-1:0]  acc_value = '0;
    logic [7:0]        alu_op;
    logic              alu_funct;
    logic [WIDTH-1:0]  imm;
    logic              in1_sel_imm;
    logic              acc_we;
    logic              acc_clr;
    logic              fault;
    logic              illegal;

    instr_sequencer #(
        .WIDTH       (WIDTH),
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_ack   (instr_ack),
        .instr_data  (instr_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .acc_value   (acc_value),
        .alu_op      (alu_op),
        .alu_funct   (alu_funct),
        .imm         (imm),
        .in1_sel_imm (in1_sel_imm),
        .acc_we      (acc_we),
        .acc_clr     (acc_clr),
        .fault       (fault),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Program memory and ALU opcode list
    logic [15:0] prog [256];
    logic [7:0]  alu_ops [11];

    // Instruction-level reference model
    int          m_pc;
    int          m_stack [$];
    bit          m_fault;
    bit          m_halted;
    bit          have_cur;
    logic [7:0]  cur_op;
    logic [7:0]  cur_opd;
    int          exp_we, exp_ill, exp_clr, exp_gap, exp_mem_cycles;
    bit          is_mem;
    int          t_we, t_ill, t_clr, t_gap, t_mem, h_req;
    int          n_fetch;

    // Memory responder state
    bit f_busy, d_busy;
    int f_wait, d_wait;

    function automatic bit model_is_alu(input logic [7:0] op);
        bit r = 0;
        for (int i = 0; i < 11; i++) if (alu_ops[i] == op) r = 1;
        return r;
    endfunction

    function automatic logic [15:0] gen_instr();
        int         r   = $urandom_range(0, 99);
        logic [7:0] opd = 8'($urandom);
        logic [7:0] op;
        if      (r < 40) op = alu_ops[$urandom_range(0, 10)];
        else if (r < 46) op = c_op_ld;
        else if (r < 52) op = c_op_st;
        else if (r < 57) op = c_op_jmp;
        else if (r < 61) op = c_op_jma;
        else if (r < 71) op = c_op_cll;
        else if (r < 79) op = c_op_ret;
        else if (r < 86) op = c_op_nop;
        else if (r < 89) op = c_op_rst;
        else if (r < 93) op = 8'hFF;
        else             op = 8'($urandom_range(8'h13, 8'hFE));
        return {op, opd};
    endfunction

    task automatic clear_tallies();
        t_we = 0; t_ill = 0; t_clr = 0; t_gap = 0; t_mem = 0;
    endtask

    // Called at the first request cycle after an instruction finished
    task automatic finish_instr();
        check("acc_we_pulses",  t_we,  exp_we);
        check("illegal_pulses", t_ill, exp_ill);
        check("acc_clr_pulses", t_clr, exp_clr);
        check("mem_issued",     t_mem != 0, is_mem);
        check("mem_req_cycles", t_mem, exp_mem_cycles);
        check("cycles_to_next_fetch", t_gap, is_mem ? 1 + exp_mem_cycles : exp_gap);
        check("fault_flag",     fault, m_fault);
        have_cur = 0;
        clear_tallies();
    endtask

    // Called at the fetch-acknowledge cycle: execute one instruction in the model
    task automatic start_instr();
        logic [15:0] w;
        check("fetch_addr", instr_addr, m_pc);
        w        = prog[m_pc];
        cur_op   = w[15:8];
        cur_opd  = w[7:0];
        m_pc     = (m_pc + 1) % 256;
        n_fetch++;
        acc_value = 16'($urandom);
        exp_we = 0; exp_ill = 0; exp_clr = 0; exp_gap = 1; exp_mem_cycles = 0; is_mem = 0;
        if (model_is_alu(cur_op)) begin
            exp_we  = 1;
            exp_gap = 2;
        end else begin
            case (cur_op)
                c_op_ld:  begin is_mem = 1; exp_we = 1; end
                c_op_st:  is_mem = 1;
                c_op_jmp: m_pc = cur_opd;
                c_op_jma: m_pc = acc_value[7:0];
                c_op_cll: begin
                    if (m_stack.size() == DEPTH) begin
                        m_fault = 1; m_halted = 1;
                    end else begin
                        m_stack.push_back(m_pc);
                        m_pc = cur_opd;
                    end
                end
                c_op_ret: begin
                    if (m_stack.size() == 0) begin
                        m_fault = 1; m_halted = 1;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                end
                c_op_nop: ;
                c_op_rst: begin
                    m_pc = 0;
                    m_stack.delete();
                    exp_clr = 1;
                end
                default: exp_ill = 1;
            endcase
        end
        have_cur = 1;
    endtask

    task automatic observe();
        if (instr_req && have_cur && !m_halted) finish_instr();
        if (acc_we) begin
            t_we++;
            check("alu_op_at_we",  alu_op, cur_op);
            check("in1_sel_imm",   in1_sel_imm, cur_op == c_op_ldi);
            check("alu_funct",     alu_funct, 0);
            if (cur_op == c_op_ldi) check("imm", imm, {8'h00, cur_opd});
        end
        if (illegal) t_ill++;
        if (acc_clr) t_clr++;
        if (!instr_req) begin
            t_gap++;
            if (mem_req) begin
                t_mem++;
                check("mem_addr",       mem_addr, cur_opd);
                check("mem_we",         mem_we, cur_op == c_op_st);
                check("alu_op_in_mem",  alu_op, cur_op);
                check("acc_we_vs_ack",  acc_we, mem_ack && (cur_op == c_op_ld));
            end
        end
        if (m_halted && instr_req) h_req++;
        if (instr_req && instr_ack && !m_halted) start_instr();
    endtask

    // One clock: drive acknowledges just after the edge, observe at the falling edge
    task automatic step();
        @(posedge clk);
        #1;
        if (instr_req) begin
            if (!f_busy) begin
                f_busy = 1;
                f_wait = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            end
            if (f_wait == 0) begin
                instr_ack  = 1'b1;
                instr_data = prog[instr_addr];
                f_busy     = 0;
            end else begin
                instr_ack  = 1'b0;
                instr_data = 16'($urandom);
                f_wait--;
            end
        end else begin
            instr_ack  = ($urandom_range(0, 3) == 0);
            instr_data = 16'($urandom);
            f_busy     = 0;
        end
        if (mem_req) begin
            if (!d_busy) begin
                d_busy         = 1;
                d_wait         = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
                exp_mem_cycles = d_wait + 1;
            end
            if (d_wait == 0) begin
                mem_ack = 1'b1;
                d_busy  = 0;
            end else begin
                mem_ack = 1'b0;
                d_wait--;
            end
        end else begin
            mem_ack = ($urandom_range(0, 3) == 0);
            d_busy  = 0;
        end
        @(negedge clk);
        observe();
    endtask

    // Assert reset (preferably while a fetch is pending), check reset state,
    // load a new program and release at a falling edge.
    task automatic reset_dut(input bit first, input bit nest);
        bit was_req;
        int k = 0;
        if (!first) begin
            while (!m_halted && !instr_req && k < 4) begin
                step();
                k++;
            end
        end
        was_req = instr_req;
        #2;
        rst = 1'b1;
        #1;
        if (was_req === 1'b1) check("rst_drops_instr_req", instr_req, 0);
        instr_ack = 1'b0;
        mem_ack   = 1'b0;
        f_busy = 0; d_busy = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_instr_req",  instr_req, 0);
        check("rst_instr_addr", instr_addr, 0);
        check("rst_mem_req",    mem_req, 0);
        check("rst_mem_we",     mem_we, 0);
        check("rst_mem_addr",   mem_addr, 0);
        check("rst_alu_op",     alu_op, c_op_nop);
        check("rst_strobes",    {acc_we, acc_clr, illegal, in1_sel_imm, alu_funct}, 0);
        check("rst_imm",        imm, 0);
        check("rst_fault",      fault, 0);
        for (int i = 0; i < 256; i++)
            prog[i] = nest ? {c_op_cll, 8'(i + 1)} : gen_instr();
        m_pc = 0; m_stack.delete(); m_fault = 0; m_halted = 0; have_cur = 0;
        h_req = 0; n_fetch = 0;
        clear_tallies();
        rst = 1'b0;
        #1;
        check("no_req_before_first_clock", instr_req, 0);
    endtask

    task automatic run_segment(input bit first, input bit nest, input int n_instr);
        int cyc = 0;
        reset_dut(first, nest);
        while (!m_halted && n_fetch < n_instr && cyc < 3000) begin
            step();
            cyc++;
        end
        if (m_halted) begin
            repeat (6) step();
            check("halt_fault",       fault, 1);
            check("halt_instr_req",   instr_req, 0);
            check("halt_mem_req",     mem_req, 0);
            check("halt_alu_op",      alu_op, c_op_nop);
            check("halt_no_fetch",    h_req, 0);
            check("halt_no_pulses",   t_we + t_ill + t_clr, 0);
        end else if (n_fetch < n_instr) begin
            check("segment_progress", n_fetch, n_instr);
        end
    endtask

    initial begin
        alu_ops = '{c_op_not, c_op_xor, c_op_or, c_op_and, c_op_sub, c_op_add,
                    c_op_rr, c_op_rl, c_op_dec, c_op_inc, c_op_ldi};
        // Nested-call program: 4 calls succeed, the 5th overflows the stack.
        run_segment(1'b1, 1'b1, 40);
        for (int s = 0; s < 24; s++) run_segment(1'b0, 1'b0, 40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
